// File: rtl/cpu_axi_pkg.sv
// Shared AXI4 read-channel encodings and the instruction-fetch FSM state type
// used by if_fetch_master and its optional line buffer.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0]  AXI_LEN_SINGLE = 4'd0;
  localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;

  // Word handed to IF for a completing beat: error responses become a NOP.
  function automatic logic [31:0] fetch_word(input logic [1:0]  resp,
                                             input logic [31:0] data);
    return (resp == AXI_RESP_OKAY) ? data : INSTR_NOP;
  endfunction

endpackage

// File: rtl/if_line_buf.sv
// One-entry instruction buffer (valid/addr/data) for if_fetch_master.
// Only compiled when IF_LINE_BUF_EN is defined.
`ifdef IF_LINE_BUF_EN
module if_line_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        lookup_en,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data
);

  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  // A flush wins over a same-cycle fill so the entry never survives it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q <= 1'b1;
    end
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (wr_en) begin
      addr_q <= wr_addr;
      data_q <= wr_data;
    end
  end

  assign hit      = lookup_en && valid_q && (lookup_addr == addr_q) && !flush;
  assign hit_data = data_q;

endmodule
`endif

// File: rtl/if_fetch_master.sv
// Instruction-fetch AXI4 read master: one single-beat read outstanding at a time,
// stalls IF until the word for IM_addr arrives. Optional buffer: IF_LINE_BUF_EN.
module if_fetch_master
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IM_read,
  input  logic [31:0] IM_addr,
  input  logic        buf_flush,
  output logic [31:0] IM_instruction,
  output logic        AXI_IF_stall,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic [1:0]  dbg_state
);

  // Handshakes: AR transfers when ARVALID_M && ARREADY_M at a rising edge; ARVALID_M
  // and ARADDR_M hold until then. R transfers when RVALID_M && RREADY_M; RREADY_M is
  // high for the whole DATA state so the single beat is always accepted.

  fetch_state_e state_q, state_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  last_instr_q, last_instr_d;

  logic         beat;
  logic         complete;
  logic [31:0]  resp_word;
  logic         buf_hit;
  logic [31:0]  buf_data;

  assign beat      = (state_q == ST_DATA) && RVALID_M && RLAST_M;
  assign complete  = beat && IM_read && (IM_addr == req_addr_q);
  assign resp_word = fetch_word(RRESP_M, RDATA_M);

`ifdef IF_LINE_BUF_EN
  // Only OKAY data is cached; an error NOP must be refetched next time.
  if_line_buf u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (buf_flush),
    .wr_en       (complete && (RRESP_M == AXI_RESP_OKAY)),
    .wr_addr     (req_addr_q),
    .wr_data     (RDATA_M),
    .lookup_en   ((state_q == ST_IDLE) && IM_read),
    .lookup_addr (IM_addr),
    .hit         (buf_hit),
    .hit_data    (buf_data)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, RID_M};
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, RID_M, buf_flush};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_addr_q   <= '0;
      last_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      last_instr_q <= last_instr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    last_instr_d   = last_instr_q;
    ARVALID_M      = 1'b0;
    RREADY_M       = 1'b0;
    AXI_IF_stall   = 1'b0;
    IM_instruction = last_instr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (buf_hit) begin
          IM_instruction = buf_data;
          last_instr_d   = buf_data;
        end else if (IM_read) begin
          AXI_IF_stall = 1'b1;
          req_addr_d   = IM_addr;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ARVALID_M    = 1'b1;
        AXI_IF_stall = 1'b1;
        if (ARREADY_M) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        RREADY_M     = 1'b1;
        AXI_IF_stall = 1'b1;
        if (complete) begin
          AXI_IF_stall   = 1'b0;
          IM_instruction = resp_word;
          last_instr_d   = resp_word;
          state_d        = ST_IDLE;
        end else if (beat) begin
          // Stale or unwanted beat: drop it and chase the current address.
          if (IM_read) begin
            req_addr_d = IM_addr;
            state_d    = ST_ADDR;
          end else begin
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ARID_M    = MASTER_ID;
  assign ARADDR_M  = req_addr_q;
  assign ARLEN_M   = AXI_LEN_SINGLE;
  assign ARSIZE_M  = AXI_SIZE_WORD;
  assign ARBURST_M = AXI_BURST_INCR;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_if_fetch_master.sv
// Bench for if_fetch_master: directed latency/stale/error/reset cases, then
// randomized IF and AXI-slave behaviour checked against a transaction-level model.
module tb_if_fetch_master;
  import cpu_axi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        IM_read;
  logic [31:0] IM_addr;
  logic        buf_flush;
  logic [31:0] IM_instruction;
  logic        AXI_IF_stall;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;
  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;
  logic [1:0]  dbg_state;

  if_fetch_master #(.MASTER_ID(4'd0)) dut (
    .clk(clk), .rst(rst), .IM_read(IM_read), .IM_addr(IM_addr), .buf_flush(buf_flush),
    .IM_instruction(IM_instruction), .AXI_IF_stall(AXI_IF_stall),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  // slave memory image: a fixed function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // AXI slave model
  int          ar_cnt = 0, r_cnt = 0;
  int          ar_lo = 0, ar_hi = 0, r_lo = 0, r_hi = 0, err_pct = 0;
  bit          pending = 0;
  logic [31:0] pend_addr = '0, pend_data = '0;
  logic [1:0]  pend_resp = '0;
  bit          force_en = 0;
  logic [31:0] force_data = '0;
  logic [1:0]  force_resp = '0;
  bit          prev_hold = 0;
  logic [31:0] prev_araddr = '0;
  int          stall_run = 0;

  // fetch-buffer and in-flight tracking (transaction level)
  bit          m_busy = 0;
  bit          m_bvalid = 0;
  logic [31:0] m_baddr = '0, m_bdata = '0;

  // samples taken 1 time unit before the active edge
  logic        s_stall, s_arvalid, s_rready;
  logic [31:0] s_instr, s_araddr;
  logic [1:0]  s_state;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic slave_clear();
    pending = 0; ar_cnt = 0; r_cnt = 0; prev_hold = 0; stall_run = 0;
    m_busy = 0; m_bvalid = 0;
    exp_q.delete();
  endtask

  task automatic check_cycle();
    bit done, hit;
    logic [31:0] exp_word;
    done = RVALID_M && IM_read && (pend_addr == IM_addr);
    hit  = 1'b0;
`ifdef IF_LINE_BUF_EN
    hit = !m_busy && IM_read && m_bvalid && (m_baddr == IM_addr) && !buf_flush;
`endif
    exp_word = '0;
    if (done) exp_word = (pend_resp == AXI_RESP_OKAY) ? pend_data : INSTR_NOP;
`ifdef IF_LINE_BUF_EN
    else if (hit) exp_word = m_bdata;
`endif
    if (done || hit) exp_q.push_back(exp_word);

    if (IM_read) check("stall", s_stall, !(done || hit));
    if (IM_read && !s_stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL delivery: got word %h with no word due (t=%0t)", s_instr, $time);
      end else begin
        check("instr", s_instr, exp_q.pop_front());
      end
    end
    exp_q.delete();

    // AXI-side rules
    if (pending) begin
      check("rready_in_data", s_rready, 1'b1);
      check("ar_while_busy", s_arvalid, 1'b0);
    end
    if (s_arvalid)
      check("ar_fields", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M},
            {4'd0, 4'd0, 3'b010, 2'b01});
    if (prev_hold) check("ar_stable", {s_arvalid, s_araddr}, {1'b1, prev_araddr});

    if (IM_read && s_stall) stall_run++; else stall_run = 0;
    if (stall_run > 300) begin
      n_cmp++; n_fail++;
      $display("FAIL stall_watchdog: stalled %0d cycles, required a completion", stall_run);
      stall_run = 0;
    end

`ifdef IF_LINE_BUF_EN
    if (done && pend_resp == AXI_RESP_OKAY) begin
      m_bvalid = 1; m_baddr = pend_addr; m_bdata = pend_data;
    end
    if (buf_flush) m_bvalid = 0;
    if (!m_busy) m_busy = IM_read && !hit;
    else if (RVALID_M && (!IM_read || pend_addr == IM_addr)) m_busy = 0;
`endif
  endtask

  task automatic slave_update();
    prev_hold   = s_arvalid && !ARREADY_M;
    prev_araddr = s_araddr;
    if (RVALID_M && s_rready) pending = 0;
    else if (pending && !RVALID_M && r_cnt > 0) r_cnt--;
    if (s_arvalid && ARREADY_M) begin
      pending   = 1;
      pend_addr = s_araddr;
      if (force_en) begin
        pend_data = force_data; pend_resp = force_resp;
      end else begin
        pend_data = mem_word(s_araddr);
        pend_resp = ($urandom_range(0, 99) < err_pct) ? 2'b10 : 2'b00;
      end
      r_cnt  = $urandom_range(r_hi, r_lo);
      ar_cnt = $urandom_range(ar_hi, ar_lo);
    end else if (s_arvalid && ar_cnt > 0) begin
      ar_cnt--;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clk);
    ARREADY_M = (ar_cnt == 0);
    RVALID_M  = pending && (r_cnt == 0);
    RLAST_M   = RVALID_M;
    RID_M     = 4'd0;
    RDATA_M   = RVALID_M ? pend_data : 32'($urandom);
    RRESP_M   = RVALID_M ? pend_resp : 2'b00;
    #4;
    s_stall = AXI_IF_stall; s_instr = IM_instruction; s_arvalid = ARVALID_M;
    s_araddr = ARADDR_M; s_rready = RREADY_M; s_state = dbg_state;
    if (rst) slave_clear();
    else begin
      check_cycle();
      slave_update();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_rec(input int n, output logic [15:0] st, output int arv);
    st = '0; arv = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      st = {st[14:0], s_stall};
      if (s_arvalid) arv++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] st;
    int arv;
    rst = 1; IM_read = 0; IM_addr = '0; buf_flush = 0;
    ARREADY_M = 0; RVALID_M = 0; RLAST_M = 0; RID_M = '0; RDATA_M = '0; RRESP_M = '0;
    cycle(); cycle();
    rst = 0;
    cycle();
    check("rst_arvalid", s_arvalid, 1'b0);
    check("rst_rready", s_rready, 1'b0);
    check("rst_araddr", s_araddr, 32'h0);
    check("rst_stall", s_stall, 1'b0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_state", s_state, ST_IDLE);

    // single fetch, no wait states: stall 1,1,0
    force_en = 1; force_data = 32'h0010_0093; force_resp = 2'b00;
    IM_read = 1; IM_addr = 32'h0000_0100;
    run_rec(3, st, arv);
    check("t1_stall_seq", st, 16'b110);
    check("t1_instr", s_instr, 32'h0010_0093);
    check("t1_ar_cycles", arv, 1);
    force_en = 0; IM_read = 0; cycle();

    // ARREADY held off 3 cycles: 5 stall cycles then data
    ar_cnt = 3; IM_read = 1; IM_addr = 32'h0000_0140;
    run_rec(6, st, arv);
    check("t2_stall_seq", st, 16'b111110);
    check("t2_ar_cycles", arv, 4);
    check("t2_instr", s_instr, 32'hA5A5_0140);
    IM_read = 0; cycle();

    // address moves 0x100 -> 0x200 during DATA
    r_lo = 1; r_hi = 1; IM_read = 1; IM_addr = 32'h0000_0100;
    run_rec(3, st, arv);
    check("t3_stall_pre", st, 16'b111);
    IM_addr = 32'h0000_0200;
    run_rec(1, st, arv);
    check("t3_stale_stall", st, 16'b1);
    run_rec(1, st, arv);
    check("t3_new_ar", {s_arvalid, s_araddr}, {1'b1, 32'h0000_0200});
    run_rec(2, st, arv);
    check("t3_stall_post", st, 16'b10);
    check("t3_instr", s_instr, 32'hA5A5_0200);
    r_lo = 0; r_hi = 0; IM_read = 0; cycle();

    // SLVERR on the completing beat returns a NOP
    force_en = 1; force_data = 32'hDEAD_BEEF; force_resp = 2'b10;
    IM_read = 1; IM_addr = 32'h0000_0300;
    run_rec(3, st, arv);
    check("t4_stall_seq", st, 16'b110);
    check("t4_instr", s_instr, 32'h0000_0013);
    force_en = 0; IM_read = 0; cycle();

    // reset while in ADDR
    ar_cnt = 5; IM_read = 1; IM_addr = 32'h0000_0400;
    run_rec(2, st, arv);
    check("t5_in_addr", {s_arvalid, s_state}, {1'b1, ST_ADDR});
    rst = 1; IM_read = 0;
    cycle();
    rst = 0;
    cycle();
    check("t5_arvalid", s_arvalid, 1'b0);
    check("t5_stall", s_stall, 1'b0);
    check("t5_state", s_state, ST_IDLE);
    check("t5_instr", s_instr, 32'h0);

`ifdef IF_LINE_BUF_EN
    // repeat request hits the buffer; a flush forces a miss
    IM_read = 1; IM_addr = 32'h0000_0100;
    run_rec(3, st, arv);
    check("t6_miss_seq", st, 16'b110);
    run_rec(2, st, arv);
    check("t6_hit_stall", st, 16'b00);
    check("t6_hit_no_ar", arv, 0);
    check("t6_hit_instr", s_instr, 32'hA5A5_0100);
    buf_flush = 1;
    run_rec(1, st, arv);
    check("t6_flush_miss", st, 16'b1);
    buf_flush = 0;
    run_rec(2, st, arv);
    check("t6_refetch_seq", st, 16'b10);
    check("t6_refetch_ar", arv, 1);
    IM_read = 0; cycle();
`endif

    // randomized traffic
    ar_lo = 0; ar_hi = 3; r_lo = 0; r_hi = 3; err_pct = 12;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1; IM_read = 0;
      end else begin
        rst = 0;
        if ($urandom_range(0, 9) == 0) IM_read = ~IM_read;
        if ($urandom_range(0, 4) == 0) IM_addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      end
      buf_flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    rst = 0; IM_read = 0; buf_flush = 0;
    for (int i = 0; i < 10; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_master.md
# if_fetch_master

Instruction-fetch AXI4 read master directly upstream of the IF stage. It turns the IF stage's per-cycle fetch request (`IM_read`, `IM_addr`) into single-beat AXI4 read bursts on the CPU wrapper's instruction master port. It returns `IM_instruction` and holds `AXI_IF_stall` high until the word for the current address is available.

## Interface
- `MASTER_ID`, 4'd0: value driven on `ARID_M`; R beats with other IDs are not expected.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `IM_read` in 1: fetch request from IF; low during reset/WFI.
- `IM_addr` in 32: fetch address, word aligned; may change while stalled on jump/branch.
- `buf_flush` in 1: invalidate fetch buffer (only active with `IF_LINE_BUF_EN`).
- `IM_instruction` out 32: fetched word, valid in any cycle with `IM_read && !AXI_IF_stall`.
- `AXI_IF_stall` out 1: IF must hold PC and insert bubble.
- `ARID_M` out 4, `ARADDR_M` out 32, `ARLEN_M` out 4, `ARSIZE_M` out 3, `ARBURST_M` out 2, `ARVALID_M` out 1, `ARREADY_M` in 1: AXI4 read address channel.
- `RID_M` in 4, `RDATA_M` in 32, `RRESP_M` in 2, `RLAST_M` in 1, `RVALID_M` in 1, `RREADY_M` out 1: AXI4 read data channel.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: `IM_read`=1 → latch `IM_addr` into `req_addr`, go ADDR; otherwise stay IDLE.
- ADDR: `ARVALID_M`=1, `ARADDR_M`=`req_addr`, held stable until `ARREADY_M`; handshake → DATA.
- DATA: `RREADY_M`=1.
  - On `RVALID_M && RLAST_M`, if `IM_addr == req_addr`: complete, return to IDLE.
  - Else: stale response. Discard it, latch new `IM_addr`, go ADDR.
- Fixed AR fields: `ARLEN_M`=0, `ARSIZE_M`=3'b010, `ARBURST_M`=INCR (2'b01), `ARID_M`=`MASTER_ID`.
- `AXI_IF_stall` = (IDLE && `IM_read`) || ADDR || (DATA && !(completing beat)).
- On completion, `IM_instruction` = `RDATA_M` combinationally, and the same value is registered into `last_instr`. In all other cycles `IM_instruction` = `last_instr`.
- `RRESP_M` != OKAY on the completing beat: return NOP 32'h0000_0013 instead of `RDATA_M`; no retry.
- `IM_read` dropping while in ADDR/DATA: the transaction finishes (AXI rules), the data is discarded, then IDLE.
- Reset mid-transaction: next state IDLE, all channel outputs low. The interconnect is reset by the same `rst`, so no orphan beat is tracked.

## Timing
- Reset values: `ARVALID_M`=0, `RREADY_M`=0, `ARADDR_M`=0, `AXI_IF_stall`=0, `IM_instruction`=0, `last_instr`=0, state IDLE.
- Minimum miss latency: 3 cycles.
  - Cycle 0: IDLE, stall.
  - Cycle 1: ADDR with `ARREADY_M`.
  - Cycle 2: DATA with `RVALID_M`; stall low, data valid.
- Each extra cycle of `ARREADY_M` or `RVALID_M` low adds exactly one stall cycle.
- Only one outstanding read at a time; ARVALID is never asserted while in DATA.

## Configuration
- `IF_LINE_BUF_EN` defined: one-entry buffer holds (`buf_valid`, `buf_addr`, `buf_data`), written on every OKAY completion.
  - In IDLE, `IM_read && buf_valid && IM_addr == buf_addr` is a hit: `IM_instruction`=`buf_data`, stall=0, no AXI traffic, stay IDLE.
  - `buf_flush` or `rst` clears `buf_valid`. A flush in the same cycle as a hit forces a miss.
- `IF_LINE_BUF_EN` undefined: no buffer, `buf_flush` ignored, every request goes to AXI.

## Structure
- Shared package `cpu_axi_pkg` holds:
  - the state enum typedef;
  - `AXI_BURST_INCR`, `AXI_SIZE_WORD`, `AXI_RESP_OKAY`;
  - `INSTR_NOP` = 32'h0000_0013.
- Optional sub-module `if_line_buf` implements the one-entry buffer; it is instantiated only under `IF_LINE_BUF_EN`.

## Test plan
- Single fetch of 0x0000_0100: AR/R ready immediately, `RDATA_M`=0x0010_0093 → stall high for 2 cycles; cycle 2 `IM_instruction`=0x0010_0093, stall=0.
- `ARREADY_M` delayed 3 cycles → `ARADDR_M`/`ARVALID_M` stable throughout; stall lasts 5 cycles.
- `IM_addr` changes 0x100→0x200 while in DATA → beat for 0x100 discarded, new AR with 0x200, its data delivered.
- `RRESP_M`=SLVERR → `IM_instruction`=0x0000_0013, stall drops normally.
- `rst` pulsed while in ADDR → next cycle `ARVALID_M`=0, stall=0, state IDLE.
- With `IF_LINE_BUF_EN`: two consecutive requests to 0x100 → second has zero stall and no ARVALID. After `buf_flush`, the next request to 0x100 misses.
